// File: rtl/user_locked_reg_bank.sv
// -----------------------------------------------------------------------------
// user_locked_reg_bank
//
// Purpose:
//   A small bank of NUM_REGS registers. Each register has an owner. A user
//   CLAIMs a FREE register, and the owner can then WRITE, READ and RELEASE it.
//   The ADMIN_ID user may access any register at any time. A request that is
//   not allowed is denied. Each denial pulses viol_irq and increments a
//   saturating violation counter.
//
// Configuration:
//   ULR_LOCKOUT_EN - when defined, a sticky lockout flag sets once the
//                    violation counter reaches 15. While it is set, every
//                    request from a non-admin user is denied. When the macro
//                    is undefined, lockout is tied to 0.
//
// Ports:
//   clk         in   clock, rising edge
//   rst_n       in   synchronous active-low reset
//   req_valid   in   request strobe (one request per cycle, no backpressure)
//   req_op      in   00 READ, 01 WRITE, 10 CLAIM, 11 RELEASE
//   req_addr    in   register index
//   req_id      in   requesting user
//   req_wdata   in   write data
//   rsp_valid   out  response strobe, one cycle after each request
//   rsp_ok      out  request granted
//   rsp_rdata   out  read data (zero unless a granted READ)
//   lock_status out  bit i set while register i is owned
//   viol_cnt    out  saturating denied-request count
//   viol_irq    out  one-cycle pulse with each denied response
//   lockout     out  global lockout flag
// -----------------------------------------------------------------------------
module user_locked_reg_bank #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 4,
  parameter int ID_W     = 2,
  parameter int ADMIN_ID = 2,
  parameter int ADDR_W   = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  input  logic [1:0]          req_op,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [ID_W-1:0]     req_id,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  output logic                rsp_ok,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic [NUM_REGS-1:0] lock_status,
  output logic [7:0]          viol_cnt,
  output logic                viol_irq,
  output logic                lockout
);

  localparam logic [1:0]      OP_READ    = 2'b00;
  localparam logic [1:0]      OP_WRITE   = 2'b01;
  localparam logic [1:0]      OP_CLAIM   = 2'b10;
  localparam logic [1:0]      OP_RELEASE = 2'b11;
  localparam logic [ID_W-1:0] ADMIN_ID_L = ID_W'(ADMIN_ID);

  // Per-register state
  logic [DATA_W-1:0]   data_q  [NUM_REGS];
  logic [DATA_W-1:0]   data_d  [NUM_REGS];
  logic [ID_W-1:0]     owner_q [NUM_REGS];
  logic [ID_W-1:0]     owner_d [NUM_REGS];
  logic [NUM_REGS-1:0] owned_q;
  logic [NUM_REGS-1:0] owned_d;

  // Response and violation state
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_ok_q,    rsp_ok_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              viol_irq_q,  viol_irq_d;
  logic [7:0]        viol_cnt_q,  viol_cnt_d;
  logic              lockout_q;

  // Decode helpers
  logic [NUM_REGS-1:0] hit_s;
  logic [DATA_W-1:0]   sel_data_s;
  logic [ID_W-1:0]     sel_owner_s;
  logic                sel_owned_s;
  logic                addr_ok_s;
  logic                is_admin_s;
  logic                auth_s;
  logic                grant_s;
  logic                deny_s;

  // Address decode. An index at or beyond NUM_REGS hits no register, so
  // out-of-range requests cannot change state and are denied.
  always_comb begin
    hit_s       = '0;
    sel_data_s  = '0;
    sel_owner_s = '0;
    sel_owned_s = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) begin
      hit_s[i]    = (req_addr == ADDR_W'(i));
      sel_data_s  = sel_data_s  | (data_q[i]  & {DATA_W{hit_s[i]}});
      sel_owner_s = sel_owner_s | (owner_q[i] & {ID_W{hit_s[i]}});
      sel_owned_s = sel_owned_s | (owned_q[i] & hit_s[i]);
    end
  end

  assign addr_ok_s  = |hit_s;
  assign is_admin_s = (req_id == ADMIN_ID_L);
  // While lockout is set, ownership no longer authorises a non-admin user.
  assign auth_s     = is_admin_s |
                      (sel_owned_s & (sel_owner_s == req_id) & ~lockout_q);

  // Grant decision and next-state computation for the bank and the response.
  always_comb begin
    grant_s     = 1'b0;
    rsp_rdata_d = '0;
    if (req_valid && addr_ok_s) begin
      case (req_op)
        OP_READ: begin
          grant_s     = auth_s;
          rsp_rdata_d = auth_s ? sel_data_s : '0;
        end
        OP_WRITE:   grant_s = auth_s;
        // CLAIM succeeds only on a FREE register. Re-claiming an owned
        // register is denied, even for its own owner or for the admin.
        OP_CLAIM:   grant_s = ~sel_owned_s & (is_admin_s | ~lockout_q);
        OP_RELEASE: grant_s = auth_s;
        default:    grant_s = 1'b0;
      endcase
    end else begin
      grant_s = 1'b0;
    end

    deny_s = req_valid & ~grant_s;

    for (int i = 0; i < NUM_REGS; i++) begin
      data_d[i]  = (hit_s[i] && grant_s && req_op == OP_WRITE) ? req_wdata : data_q[i];
      owner_d[i] = (hit_s[i] && grant_s && req_op == OP_CLAIM) ? req_id    : owner_q[i];
      if (hit_s[i] && grant_s && req_op == OP_CLAIM) begin
        owned_d[i] = 1'b1;
      end else if (hit_s[i] && grant_s && req_op == OP_RELEASE) begin
        owned_d[i] = 1'b0;
      end else begin
        owned_d[i] = owned_q[i];
      end
    end

    rsp_valid_d = req_valid;
    rsp_ok_d    = grant_s;
    viol_irq_d  = deny_s;
    viol_cnt_d  = (deny_s && viol_cnt_q != 8'hFF) ? viol_cnt_q + 8'd1 : viol_cnt_q;
  end

  // Bank and response registers, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        data_q[i]  <= '0;
        owner_q[i] <= '0;
      end
      owned_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_ok_q    <= 1'b0;
      rsp_rdata_q <= '0;
      viol_irq_q  <= 1'b0;
      viol_cnt_q  <= 8'd0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        data_q[i]  <= data_d[i];
        owner_q[i] <= owner_d[i];
      end
      owned_q     <= owned_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_ok_q    <= rsp_ok_d;
      rsp_rdata_q <= rsp_rdata_d;
      viol_irq_q  <= viol_irq_d;
      viol_cnt_q  <= viol_cnt_d;
    end
  end

`ifdef ULR_LOCKOUT_EN
  logic lockout_d;
  // The flag sets on the same edge at which the counter reaches 15.
  assign lockout_d = lockout_q | (viol_cnt_d >= 8'd15);

  // Sticky lockout flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      lockout_q <= 1'b0;
    end else begin
      lockout_q <= lockout_d;
    end
  end
`else
  assign lockout_q = 1'b0;
`endif

  assign rsp_valid   = rsp_valid_q;
  assign rsp_ok      = rsp_ok_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign viol_irq    = viol_irq_q;
  assign viol_cnt    = viol_cnt_q;
  assign lock_status = owned_q;
  assign lockout     = lockout_q;

endmodule

// File: tb/tb_user_locked_reg_bank.sv
// -----------------------------------------------------------------------------
// tb_user_locked_reg_bank
//
// Self-checking bench for user_locked_reg_bank. It uses NUM_REGS=3 with
// ADDR_W=2, so address 3 is out of range. A behavioural model of the bank is
// kept in plain arrays and updated once per issued request.
// -----------------------------------------------------------------------------
module tb_user_locked_reg_bank;

  localparam int DW  = 8;
  localparam int NR  = 3;
  localparam int IW  = 2;
  localparam int ADM = 2;
  localparam int AW  = 2;

  logic           clk;
  logic           rst_n;
  logic           req_valid;
  logic [1:0]     req_op;
  logic [AW-1:0]  req_addr;
  logic [IW-1:0]  req_id;
  logic [DW-1:0]  req_wdata;
  logic           rsp_valid;
  logic           rsp_ok;
  logic [DW-1:0]  rsp_rdata;
  logic [NR-1:0]  lock_status;
  logic [7:0]     viol_cnt;
  logic           viol_irq;
  logic           lockout;

  user_locked_reg_bank #(
    .DATA_W(DW), .NUM_REGS(NR), .ID_W(IW), .ADMIN_ID(ADM), .ADDR_W(AW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
    .req_id(req_id), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ok(rsp_ok), .rsp_rdata(rsp_rdata),
    .lock_status(lock_status), .viol_cnt(viol_cnt), .viol_irq(viol_irq),
    .lockout(lockout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state
  int       m_data  [NR];
  int       m_owner [NR];
  bit       m_owned [NR];
  int       m_cnt;
  bit       m_lock;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NR; i++) begin
      m_data[i] = 0; m_owner[i] = 0; m_owned[i] = 1'b0;
    end
    m_cnt  = 0;
    m_lock = 1'b0;
  endtask

  // Apply one request to the model and return the expected response.
  task automatic model_step(input int op, input int addr, input int id, input int wd,
                            output bit ok, output int rd);
    bit admin;
    bit auth;
    ok = 1'b0;
    rd = 0;
    admin = (id == ADM);
    if (addr < NR) begin
      auth = admin || (m_owned[addr] && m_owner[addr] == id && !m_lock);
      if (op == 0 && auth) begin
        ok = 1'b1; rd = m_data[addr];
      end
      if (op == 1 && auth) begin
        ok = 1'b1; m_data[addr] = wd;
      end
      if (op == 2 && !m_owned[addr] && (admin || !m_lock)) begin
        ok = 1'b1; m_owned[addr] = 1'b1; m_owner[addr] = id;
      end
      if (op == 3 && auth) begin
        ok = 1'b1; m_owned[addr] = 1'b0;
      end
    end
    if (!ok) begin
      if (m_cnt < 255) m_cnt++;
`ifdef ULR_LOCKOUT_EN
      if (m_cnt >= 15) m_lock = 1'b1;
`endif
    end
  endtask

  function automatic logic [NR-1:0] exp_lock_status();
    logic [NR-1:0] v;
    for (int i = 0; i < NR; i++) v[i] = m_owned[i];
    return v;
  endfunction

  task automatic check_state(input string tag);
    check_eq({tag, ".lock_status"}, 32'(lock_status), 32'(exp_lock_status()));
    check_eq({tag, ".viol_cnt"},    32'(viol_cnt),    32'(m_cnt));
    check_eq({tag, ".lockout"},     32'(lockout),     32'(m_lock));
  endtask

  // Issue one request and check the response one cycle later.
  task automatic do_req(input string tag, input int op, input int addr, input int id, input int wd);
    bit eok;
    int erd;
    @(negedge clk);
    req_valid = 1'b1;
    req_op    = 2'(op);
    req_addr  = AW'(addr);
    req_id    = IW'(id);
    req_wdata = DW'(wd);
    model_step(op, addr, id, wd, eok, erd);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check_eq({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd1);
    check_eq({tag, ".rsp_ok"},    32'(rsp_ok),    32'(eok));
    check_eq({tag, ".rsp_rdata"}, 32'(rsp_rdata), 32'(erd));
    check_eq({tag, ".viol_irq"},  32'(viol_irq),  32'(!eok));
    check_state(tag);
  endtask

  task automatic idle_cycle(input string tag);
    @(negedge clk);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
    check_eq({tag, ".rsp_ok"},    32'(rsp_ok),    32'd0);
    check_eq({tag, ".viol_irq"},  32'(viol_irq),  32'd0);
    check_state(tag);
  endtask

  // Reset with a write request on the bus; the request must be dropped.
  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n     = 1'b0;
    req_valid = 1'b1;
    req_op    = 2'b01;
    req_addr  = '0;
    req_id    = IW'(ADM);
    req_wdata = 8'hFF;
    @(posedge clk);
    #1;
    model_reset();
    check_eq({tag, ".rsp_valid"}, 32'(rsp_valid), 32'd0);
    check_eq({tag, ".rsp_ok"},    32'(rsp_ok),    32'd0);
    check_eq({tag, ".rsp_rdata"}, 32'(rsp_rdata), 32'd0);
    check_eq({tag, ".viol_irq"},  32'(viol_irq),  32'd0);
    check_state(tag);
    @(negedge clk);
    rst_n     = 1'b1;
    req_valid = 1'b0;
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_addr  = '0;
    req_id    = '0;
    req_wdata = '0;
    model_reset();
    do_reset("rst0");
    do_reset("rst1");

    // Basic read after reset; the write presented during reset is not loaded
    do_req("rd0_admin", 0, 0, 2, 0);
    idle_cycle("idle0");

    // Claim, owner write, foreign write, owner read
    do_req("claim1",   2, 1, 1, 0);
    do_req("wr1_own",  1, 1, 1, 8'hA5);
    do_req("wr1_other",1, 1, 3, 8'h5A);
    do_req("rd1_own",  0, 1, 1, 0);
    // Claim on an owned register, including by its own owner
    do_req("claim1_0", 2, 1, 0, 0);
    do_req("claim1_1", 2, 1, 1, 0);
    do_req("rd1_foreign", 0, 1, 0, 0);
    // Admin releases another user's register
    do_req("rel1_adm", 3, 1, 2, 0);
    do_req("rd1_after_rel", 0, 1, 1, 0);
    // Out-of-range address with every op
    for (int op = 0; op < 4; op++) do_req("oob", op, 3, 2, 8'h33);
    idle_cycle("idle1");

    // Randomized traffic with occasional idle cycles
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        idle_cycle("rnd_idle");
      end else begin
        do_req("rnd", int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), int'($urandom_range(0, 255)));
      end
    end

    // Counter saturation, then reset in the middle of a request stream
    do_reset("rst2");
    for (int n = 0; n < 260; n++) do_req("sat", 1, 3, 1, n & 8'hFF);
    check_eq("sat.final", 32'(viol_cnt), 32'd255);
    do_reset("rst_mid");

    // Lockout scenario: the model expects lockout only in the lockout build
    do_req("lk_claim", 2, 0, 1, 0);
    for (int n = 0; n < 15; n++) do_req("lk_deny", 0, 0, 3, 0);
    do_req("lk_own_wr", 1, 0, 1, 8'h11);
    do_req("lk_adm_wr", 1, 0, 2, 8'h22);
    do_req("lk_adm_rd", 0, 0, 2, 0);
    do_req("lk_rd_own", 0, 0, 1, 0);
    idle_cycle("idle_end");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/user_locked_reg_bank.md
USER_LOCKED_REG_BANK -- requirements
Module: user_locked_reg_bank

Interface
REQ-001 Parameter DATA_W, default 8, register data width.
REQ-002 Parameter NUM_REGS, default 4, number of registers (1..16, need not be a power of two).
REQ-003 Parameter ID_W, default 2, user ID width.
REQ-004 Parameter ADMIN_ID, default 2, privileged user ID.
REQ-005 Parameter ADDR_W, default 2, address width; must satisfy 2**ADDR_W >= NUM_REGS.
REQ-006 clk  input  1  clock; all state updates on rising edge.
REQ-007 rst_n  input  1  reset, synchronous, active-low.
REQ-008 req_valid  input  1  request strobe; one request per asserted cycle, no backpressure.
REQ-009 req_op  input  2  00 READ, 01 WRITE, 10 CLAIM, 11 RELEASE.
REQ-010 req_addr  input  ADDR_W  register index.
REQ-011 req_id  input  ID_W  requesting user.
REQ-012 req_wdata  input  DATA_W  write data.
REQ-013 rsp_valid  output  1  response strobe, exactly 1 cycle after each accepted req_valid.
REQ-014 rsp_ok  output  1  request granted; valid only with rsp_valid.
REQ-015 rsp_rdata  output  DATA_W  read data; zero unless a granted READ.
REQ-016 lock_status  output  NUM_REGS  bit i = 1 while register i is OWNED.
REQ-017 viol_cnt  output  8  saturating denied-request count.
REQ-018 viol_irq  output  1  one-cycle pulse, coincident with rsp_valid, on every denied request.
REQ-019 lockout  output  1  global lockout flag.

Function
REQ-020 Each register SHALL hold data[DATA_W], owner[ID_W] and state FREE/OWNED.
REQ-021 Authorised = (state OWNED and owner == req_id) or req_id == ADMIN_ID.
REQ-022 CLAIM SHALL succeed only if FREE: state becomes OWNED, owner = req_id; CLAIM on OWNED is denied, including when req_id already owns the register.
REQ-023 RELEASE SHALL succeed if authorised: state becomes FREE, data unchanged; otherwise denied.
REQ-024 WRITE SHALL update data with req_wdata if authorised; otherwise data is unchanged and the request is denied.
REQ-025 READ SHALL return data on rsp_rdata with rsp_ok=1 if authorised; otherwise rsp_rdata=0 and the request is denied.
REQ-026 Any op with req_addr >= NUM_REGS SHALL be denied with no state change.
REQ-027 Effects of a request SHALL be visible to a request issued in the next cycle; back-to-back requests are processed in order.
REQ-028 A denied request SHALL set rsp_ok=0, pulse viol_irq, and increment viol_cnt, saturating at 255.
REQ-029 rsp_valid, rsp_ok and viol_irq SHALL be 0 in cycles without a response.

Reset
REQ-030 When rst_n=0 at a clock edge: all data=0, all FREE, owners=0, rsp_valid=0, rsp_ok=0, rsp_rdata=0, viol_cnt=0, viol_irq=0, lockout=0.
REQ-031 A request presented in a reset cycle SHALL be dropped with no response.
REQ-032 Reset SHALL NOT load req_wdata into any register.

Configuration
REQ-033 Macro ULR_LOCKOUT_EN: when defined, lockout SHALL set on the edge at which viol_cnt reaches 15 and remain set until reset.
REQ-034 While lockout=1, every non-ADMIN_ID request SHALL be denied regardless of ownership; ADMIN_ID requests follow REQ-021..026.
REQ-035 Without ULR_LOCKOUT_EN, lockout SHALL be tied 0 and no lockout logic is synthesised.

Verification
REQ-036 Reset, then READ reg0 id=2 -> rsp_valid=1 1 cycle later, rsp_ok=1, rsp_rdata=0; lock_status=0.
REQ-037 CLAIM reg1 id=1; WRITE reg1 id=1 0xA5; WRITE reg1 id=3 0x5A; READ reg1 id=1 -> ok, ok, denied (viol_irq, viol_cnt=1), rdata=0xA5.
REQ-038 CLAIM reg1 id=0 while owned by id=1 -> denied; RELEASE reg1 id=2 -> ok, lock_status[1]=0.
REQ-039 WRITE addr=3 with NUM_REGS=3 -> denied, viol_cnt increments, no register changes.
REQ-040 256 denied requests -> viol_cnt holds 255; rst_n=0 mid-stream -> all outputs 0 on the next cycle.
REQ-041 ULR_LOCKOUT_EN: 15 denials -> lockout=1; owner id=1 WRITE denied; id=2 WRITE ok.
